hog_cell_hist: RTL
==================

Name: hog_cell_hist

Overview:
- Upstream stage of the HOG cell/block assembler. Consumes a cell-major pixel stream of gradient magnitude and orientation.
- Soft-bins each pixel's magnitude into two adjacent orientation bins. Accumulates 64 pixels (one 8x8 cell) into a 9-bin histogram.
- Emits the histogram as one 288-bit word (bin, i_valid-style strobe, addr_fw), which the block assembler consumes directly.

Parameters:
- NUM_CELLS, 4800, cells per frame; addr_fw wraps from NUM_CELLS-1 to 0.
- MAG_W, 16, gradient magnitude width.
- FRAC_W, 8, orientation interpolation weight width.
- BIN_W, 32, accumulator width per bin.
- DATA_W, 288, output width; must equal 9*BIN_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_valid  in  1  pixel strobe; one pixel per asserted cycle, no backpressure
- i_sof  in  1  first pixel of frame; qualified by i_valid
- i_mag  in  MAG_W  gradient magnitude, unsigned
- i_bin  in  4  lower orientation bin, legal range 0..8
- i_frac  in  FRAC_W  weight toward upper bin, 0..255
- o_valid  out  1  one-cycle pulse; histogram valid
- bin  out  DATA_W  histogram; bin k at [k*BIN_W +: BIN_W]
- addr_fw  out  13  cell index of the emitted histogram
- o_err  out  1  sticky flag: illegal i_bin seen

Behaviour:
- Reset (rst==0 at posedge): o_valid=0, bin=0, addr_fw=0, o_err=0. Accumulators, pixel counter, cell counter and pipeline valids are cleared. A partially accumulated cell is discarded.
- Split stage (registered, stage 1):
  - lo = (i_mag*(256-i_frac))>>8, truncated.
  - hi = i_mag - lo, so magnitude is exactly conserved.
  - lo targets bin i_bin; hi targets (i_bin==8) ? 0 : i_bin+1.
- Illegal i_bin (9..15): pixel still counts toward the 64. Both contributions are 0. o_err is set and held until reset.
- Accumulate stage (stage 2): the two target bins add lo/hi. When i_bin==8 and hi lands in bin 0, both adds happen in the same cycle, to different bins.
- Pixel counter 0..63 advances on each stage-1 valid.
- On the 64th pixel:
  - bin <= acc + contributions.
  - acc <= 0 in the same cycle, so the next cell's pixel may arrive on the immediately following cycle.
  - o_valid pulses.
  - addr_fw <= current cell counter; the cell counter then increments with wrap.
- Latency: o_valid asserts exactly 2 cycles after the cycle in which the 64th pixel is presented at the inputs.
- bin and addr_fw hold their values between pulses.
- Width: max cell sum is 64*65535 < 2^22. No overflow handling is required with BIN_W=32.
- i_sof with i_valid:
  - Any in-progress partial cell is discarded without emission.
  - The pixel counter restarts with this pixel as pixel 0.
  - The cell counter resets, so this cell emits addr_fw=0.
  - A histogram already in the pipeline (64th pixel presented 1 cycle earlier) still emits normally.
- i_sof without i_valid is ignored.
- i_valid gaps are allowed anywhere; the counter only advances on valid.

Decomposition:
- Package hog_pkg: NUM_BINS=9, CELL_PIX=64, BIN_W, DATA_W, ADDR_W=13, FRAC_W, MAG_W, and the bin-slice index helper.
- One sub-module, hog_bin_split: registered stage 1 producing lo, hi, lo_idx, hi_idx and a zero-contribution flag for illegal bins.

Test Plan:
- 64 pixels back-to-back, mag=100, bin=2, frac=0 -> one o_valid 2 cycles after the last pixel; bin2=6400, all other bins 0; addr_fw=0.
- 64 pixels, mag=100, bin=8, frac=128 -> bin8=3200, bin0=3200, all others 0 (wrap split).
- 64 pixels, mag=65535, bin=0, frac=255 -> bin0=64*255=16320, bin1=64*65280=4177920.
- NUM_CELLS=4: 5 cells back-to-back -> addr_fw sequence 0,1,2,3,0; o_valid pulses exactly 64 cycles apart; first pixel of each next cell is accepted with no gap.
- 30 pixels, then i_sof with i_valid, then 64 pixels mag=1, bin=0, frac=0 -> no emission for the partial cell; one emission with bin0=64 and addr_fw=0.
- Mix of 10 pixels with bin=9 into a cell of mag=1, bin=4, frac=0 -> bin4=54, o_err=1 and sticky. Then rst low for 1 cycle after 40 pixels of the next cell -> all outputs 0, o_err=0; the next 64 pixels emit addr_fw=0.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared constants, the stage-1 record and the bin-slice helper for the HOG cell histogram.
package hog_pkg;

    localparam int NUM_BINS = 9;
    localparam int CELL_PIX = 64;
    localparam int MAG_W    = 16;
    localparam int FRAC_W   = 8;
    localparam int BIN_W    = 32;
    localparam int DATA_W   = NUM_BINS * BIN_W;
    localparam int ADDR_W   = 13;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 6;

    // One split pixel travelling from stage 1 to stage 2.
    typedef struct packed {
        logic             valid;
        logic             sof;
        logic             zero;
        logic [IDX_W-1:0] lo_idx;
        logic [IDX_W-1:0] hi_idx;
        logic [MAG_W-1:0] lo;
        logic [MAG_W-1:0] hi;
    } split_t;

    // LSB position of bin k inside the packed histogram word.
    function automatic int bin_lsb(input int k);
        return k * BIN_W;
    endfunction

endpackage

// File: rtl/hog_bin_split.sv
// Stage 1: splits a pixel magnitude between its lower and upper orientation bins.
module hog_bin_split
    import hog_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              sof_i,
    input  logic [MAG_W-1:0]  mag_i,
    input  logic [IDX_W-1:0]  bin_i,
    input  logic [FRAC_W-1:0] frac_i,
    output split_t            split_o
);

    logic [FRAC_W:0]         weight;
    logic [MAG_W+FRAC_W:0]   prod;
    logic [MAG_W-1:0]        lo_raw;
    logic                    illegal;
    split_t                  split_d;
    split_t                  split_q;

    // Compute the lower-bin share; the upper share is the remainder so the total is exact.
    always_comb begin
        weight  = 9'd256 - {1'b0, frac_i};
        prod    = (MAG_W+FRAC_W+1)'(mag_i) * (MAG_W+FRAC_W+1)'(weight);
        lo_raw  = prod[FRAC_W +: MAG_W];
        illegal = (bin_i > IDX_W'(NUM_BINS-1));

        split_d        = '0;
        split_d.valid  = valid_i;
        split_d.sof    = valid_i & sof_i;
        split_d.zero   = illegal;
        if (!illegal) begin
            split_d.lo     = lo_raw;
            split_d.hi     = mag_i - lo_raw;
            split_d.lo_idx = bin_i;
            split_d.hi_idx = (bin_i == IDX_W'(NUM_BINS-1)) ? '0 : bin_i + 1'b1;
        end
    end

    // Register the split pixel; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            split_q <= '0;
        end else begin
            split_q <= split_d;
        end
    end

    assign split_o = split_q;

endmodule

// File: rtl/hog_cell_hist.sv
// Accumulates 64 soft-binned pixels per cell into a 9-bin histogram and emits it with its cell index.
module hog_cell_hist
    import hog_pkg::*;
#(
    parameter int NUM_CELLS = 4800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [MAG_W-1:0]  i_mag,
    input  logic [3:0]        i_bin,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_valid,
    output logic [DATA_W-1:0] bin,
    output logic [ADDR_W-1:0] addr_fw,
    output logic              o_err
);

    split_t                             s1;
    logic [NUM_BINS-1:0][BIN_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]                  bin_q, bin_d;
    logic [CNT_W-1:0]                   pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]                  cell_cnt_q, cell_cnt_d;
    logic [ADDR_W-1:0]                  addr_q, addr_d;
    logic                               valid_q, valid_d;
    logic                               err_q, err_d;
    logic [CNT_W-1:0]                   base_cnt;
    logic [ADDR_W-1:0]                  base_cell;
    logic                               last;
    logic [BIN_W-1:0]                   sum_v;

    hog_bin_split u_split (
        .clk     (clk),
        .rst     (rst),
        .valid_i (i_valid),
        .sof_i   (i_sof),
        .mag_i   (i_mag),
        .bin_i   (i_bin),
        .frac_i  (i_frac),
        .split_o (s1)
    );

    // Stage 2: add the two contributions; a start-of-frame pixel restarts the cell from empty.
    always_comb begin
        acc_d      = acc_q;
        bin_d      = bin_q;
        pix_cnt_d  = pix_cnt_q;
        cell_cnt_d = cell_cnt_q;
        addr_d     = addr_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        base_cnt   = s1.sof ? '0 : pix_cnt_q;
        base_cell  = s1.sof ? '0 : cell_cnt_q;
        last       = (base_cnt == CNT_W'(CELL_PIX-1));
        sum_v      = '0;

        if (s1.valid) begin
            if (s1.zero) begin
                err_d = 1'b1;
            end
            for (int k = 0; k < NUM_BINS; k++) begin
                sum_v = s1.sof ? '0 : acc_q[k];
                if (s1.lo_idx == IDX_W'(k)) sum_v = sum_v + BIN_W'(s1.lo);
                if (s1.hi_idx == IDX_W'(k)) sum_v = sum_v + BIN_W'(s1.hi);
                if (last) begin
                    bin_d[bin_lsb(k) +: BIN_W] = sum_v;
                    acc_d[k]                   = '0;
                end else begin
                    acc_d[k] = sum_v;
                end
            end
            if (last) begin
                valid_d    = 1'b1;
                addr_d     = base_cell;
                pix_cnt_d  = '0;
                cell_cnt_d = (base_cell == ADDR_W'(NUM_CELLS-1)) ? '0 : base_cell + 1'b1;
            end else begin
                pix_cnt_d  = base_cnt + 1'b1;
                cell_cnt_d = base_cell;
            end
        end
    end

    // Stage-2 state and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q      <= '0;
            bin_q      <= '0;
            pix_cnt_q  <= '0;
            cell_cnt_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            bin_q      <= bin_d;
            pix_cnt_q  <= pix_cnt_d;
            cell_cnt_q <= cell_cnt_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign o_valid = valid_q;
    assign bin     = bin_q;
    assign addr_fw = addr_q;
    assign o_err   = err_q;

endmodule
